load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Initiator side of the core's data-memory interface. Takes one load/store request from the execute stage.
// - Computes the effective address, checks funct3 / alignment / range, then drives a single read or write
//   into the byte-addressed data memory. That memory has 1-cycle registered read latency and returns
//   loads already sign/zero-extended.
// - Returns the load data or store completion to the core over a valid/ready response.
// PARAMETERS
// - MEMSIZE  64  data-memory size in bytes; any access touching a byte >= MEMSIZE is an access fault
// PORTS
// - clk             in   1   single clock, all state updates on posedge
// - reset           in   1   synchronous, active-high
// - req_valid       in   1   core presents a request
// - req_ready       out  1   LSU can accept; high only in IDLE
// - req_store       in   1   1 = store, 0 = load
// - req_funct3      in   3   RV32I width/sign code
// - req_base        in   32  rs1 value
// - req_offset      in   32  sign-extended immediate
// - req_wdata       in   32  rs2 value (store data)
// - resp_valid      out  1   response available
// - resp_ready      in   1   core accepts response
// - resp_rdata      out  32  load result (0 for stores and faults)
// - resp_fault      out  2   0 none, 1 misaligned, 2 access fault, 3 illegal funct3
// - resp_fault_addr out  32  effective address of the request (valid with resp_valid)
// - mem_addr        out  32  to memory: byte address
// - mem_value       out  32  to memory: store data
// - mem_funct3      out  3   to memory: width code
// - mem_read        out  1   to memory: read strobe
// - mem_write       out  1   to memory: write strobe
// - mem_data        in   32  from memory: load data, valid the cycle after mem_read
// BEHAVIOUR
// - Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, resp_fault_addr=0,
//   mem_read=0, mem_write=0, mem_addr=0, mem_value=0, mem_funct3=0.
// - EA = req_base + req_offset, modulo 2^32; wrap-around is legal and is then range-checked.
// - Checks at accept, first match wins:
//   1. Illegal funct3: load not in {0,1,2,4,5}, store not in {0,1,2} -> fault 3.
//   2. Misaligned: half with EA[0]!=0, word with EA[1:0]!=0 -> fault 1.
//   3. Range: EA + bytes - 1 >= MEMSIZE, computed in 33 bits so no wrap -> fault 2.
// - States:
//   - IDLE: on req_valid & req_ready, latch EA/funct3/wdata/store.
//     - Fault -> RESP (resp_fault set, no memory strobe ever asserted).
//     - Otherwise -> ISSUE.
//   - ISSUE: exactly one cycle with mem_read (load) or mem_write (store) = 1; mem_addr/value/funct3 stable. -> WAIT.
//   - WAIT: strobes 0; for loads, mem_data sampled at the end of this cycle into resp_rdata. -> RESP.
//   - RESP: resp_valid=1; all resp_* outputs held stable until resp_ready. On resp_valid & resp_ready -> IDLE.
// - Latency: request accepted at edge N -> strobe in cycle N+1 -> resp_valid from cycle N+3 (loads and stores).
//   Faulted request: resp_valid from cycle N+1.
// - Throughput: req_ready=0 outside IDLE; a new request cannot be accepted in the same cycle as the response handshake.
// - req_valid while busy is ignored; the core must hold it.
// - Reset mid-operation: the next edge forces IDLE and clears every output.
//   A write strobe already present in ISSUE still completes at that same edge; its response is discarded.
// - Stores: mem_value = req_wdata unmodified; memory selects bytes per funct3.
// CONFIGURATION
// - LSU_RVFI_EN defined: adds outputs rvfi_mem_addr(32), rvfi_mem_rmask(4), rvfi_mem_wmask(4),
//   rvfi_mem_rdata(32), rvfi_mem_wdata(32).
//   - All are valid with resp_valid; reset to 0.
//   - Masks: byte=0001, half=0011, word=1111, 0 on fault or for the other direction.
//   - wdata masked to the access width.
// - LSU_RVFI_EN undefined: those ports and their logic do not exist; all other behaviour identical.
// TESTING
// - Load word: base=0x10, off=4, funct3=2, mem[0x14..0x17]=78 56 34 12
//   -> mem_read one cycle, addr 0x14; resp_rdata=0x12345678 at N+3, fault=0.
// - Load byte: sign (f3=0) and unsigned (f3=4) of 0x80
//   -> rdata=0xFFFFFF80 and 0x00000080 respectively.
// - Store half: EA=0x21, f3=1 -> fault=1, resp at N+1, mem_write never asserted.
// - Store word: EA=0x3C ok, then EA=0x3D (misaligned, fault 1) and EA=0x40 (fault 2).
//   base=0xFFFFFFFC, off=8 wraps to 0x4 -> ok.
// - Load with f3=3 -> fault 3. Store with f3=4 -> fault 3.
// - Backpressure: hold resp_ready=0 for 5 cycles -> outputs stable, req_ready=0.
// - Reset: assert reset in WAIT -> IDLE next cycle, resp_valid never rises.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Bundle of the load/store unit's request, response and
//               data-memory signals.
//               master : core/memory side (drives requests, resp_ready and
//                        mem_data)
//               slave  : load/store unit side
//               Optional LSU_RVFI_EN adds the rvfi_mem_* trace signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    // request from the execute stage
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    // response to the core
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic [31:0] resp_fault_addr;
    // data-memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_value;
    logic [2:0]  mem_funct3;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data;
`ifdef LSU_RVFI_EN
    logic [31:0] rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask;
    logic [3:0]  rvfi_mem_wmask;
    logic [31:0] rvfi_mem_rdata;
    logic [31:0] rvfi_mem_wdata;
`endif

    modport master (
        output req_valid, req_store, req_funct3, req_base, req_offset, req_wdata,
        output resp_ready, mem_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_addr,
        input  mem_addr, mem_value, mem_funct3, mem_read, mem_write
`ifdef LSU_RVFI_EN
        ,
        input  rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
        input  rvfi_mem_rdata, rvfi_mem_wdata
`endif
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_base, req_offset, req_wdata,
        input  resp_ready, mem_data,
        output req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_addr,
        output mem_addr, mem_value, mem_funct3, mem_read, mem_write
`ifdef LSU_RVFI_EN
        ,
        output rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
        output rvfi_mem_rdata, rvfi_mem_wdata
`endif
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Initiator side of the data-memory interface. Accepts one
//               load/store, computes EA = base + offset, checks funct3,
//               alignment and range, issues a single read or write strobe
//               and returns data / completion over a valid/ready response.
// Ports       : clk   - clock
//               reset - synchronous active-high reset
//               bus   - load_store_unit_if.slave (request, response, memory)
// Parameters  : MEMSIZE - data-memory size in bytes
// Options     : LSU_RVFI_EN - adds rvfi_mem_* trace outputs
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEMSIZE = 64
) (
    input  wire logic         clk,
    input  wire logic         reset,
    load_store_unit_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [32:0] c_memsize = 33'(MEMSIZE);

    logic [1:0]  r_state;
    logic [31:0] r_ea;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic        r_store;
    logic [31:0] r_rdata;
    logic [1:0]  r_fault;

    logic [31:0] w_ea;
    logic [32:0] w_bytes;
    logic [32:0] w_last;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_range;
    logic [1:0]  w_fault;

    assign w_ea = bus.req_base + bus.req_offset;

    always_comb begin
        w_bytes = 33'd1;
        case (bus.req_funct3[1:0])
            2'd1:    w_bytes = 33'd2;
            2'd2:    w_bytes = 33'd4;
            default: w_bytes = 33'd1;
        endcase

        if (bus.req_store)
            w_illegal = (bus.req_funct3 > 3'd2);
        else
            w_illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 > 3'd5);

        w_misaligned = ((bus.req_funct3[1:0] == 2'd1) && w_ea[0]) ||
                       ((bus.req_funct3[1:0] == 2'd2) && (w_ea[1:0] != 2'b00));

        // 33-bit sum so an EA near 2^32 cannot wrap back into range
        w_last  = {1'b0, w_ea} + w_bytes - 33'd1;
        w_range = (w_last >= c_memsize);

        if (w_illegal)
            w_fault = 2'd3;
        else if (w_misaligned)
            w_fault = 2'd1;
        else if (w_range)
            w_fault = 2'd2;
        else
            w_fault = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ea     <= 32'd0;
            r_funct3 <= 3'd0;
            r_wdata  <= 32'd0;
            r_store  <= 1'b0;
            r_rdata  <= 32'd0;
            r_fault  <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_ea     <= w_ea;
                        r_funct3 <= bus.req_funct3;
                        r_wdata  <= bus.req_wdata;
                        r_store  <= bus.req_store;
                        r_rdata  <= 32'd0;
                        r_fault  <= w_fault;
                        // faulted requests skip memory entirely
                        r_state  <= (w_fault != 2'd0) ? RESP : ISSUE;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (!r_store)
                        r_rdata <= bus.mem_data;
                    r_state <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // strobes decode from state so a write in ISSUE still reaches memory
    // at the edge where a reset is being applied
    assign bus.req_ready       = (r_state == IDLE);
    assign bus.resp_valid      = (r_state == RESP);
    assign bus.mem_read        = (r_state == ISSUE) && !r_store;
    assign bus.mem_write       = (r_state == ISSUE) &&  r_store;
    assign bus.mem_addr        = r_ea;
    assign bus.mem_value       = r_wdata;
    assign bus.mem_funct3      = r_funct3;
    assign bus.resp_rdata      = r_rdata;
    assign bus.resp_fault      = r_fault;
    assign bus.resp_fault_addr = r_ea;

`ifdef LSU_RVFI_EN
    logic [3:0] w_mask;
    logic       w_ok;

    always_comb begin
        case (r_funct3[1:0])
            2'd1:    w_mask = 4'b0011;
            2'd2:    w_mask = 4'b1111;
            default: w_mask = 4'b0001;
        endcase
        w_ok = bus.resp_valid && (r_fault == 2'd0);
    end

    assign bus.rvfi_mem_addr  = r_ea;
    assign bus.rvfi_mem_rmask = (w_ok && !r_store) ? w_mask : 4'b0000;
    assign bus.rvfi_mem_wmask = (w_ok &&  r_store) ? w_mask : 4'b0000;
    assign bus.rvfi_mem_rdata = r_rdata;
    assign bus.rvfi_mem_wdata = r_wdata & {{8{bus.rvfi_mem_wmask[3]}}, {8{bus.rvfi_mem_wmask[2]}},
                                           {8{bus.rvfi_mem_wmask[1]}}, {8{bus.rvfi_mem_wmask[0]}}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               64-byte data-memory model (1-cycle registered read,
//               sign/zero-extended load data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    load_store_unit_if bus ();

    load_store_unit #(.MEMSIZE(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [7:0]  mem [64];
    logic [31:0] r_mem_data;
    int          n_rd;
    int          n_wr;

    assign bus.mem_data = r_mem_data;

    always @(posedge clk) begin
        logic [5:0] a;
        a = bus.mem_addr[5:0];
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'h00;
            mem[6'h14] = 8'h78; mem[6'h15] = 8'h56;
            mem[6'h16] = 8'h34; mem[6'h17] = 8'h12;
            mem[6'h20] = 8'h80;
        end
        if (bus.mem_write) begin
            n_wr <= n_wr + 1;
            mem[a] = bus.mem_value[7:0];
            if (bus.mem_funct3[1:0] != 2'd0) mem[a+6'd1] = bus.mem_value[15:8];
            if (bus.mem_funct3[1:0] == 2'd2) begin
                mem[a+6'd2] = bus.mem_value[23:16];
                mem[a+6'd3] = bus.mem_value[31:24];
            end
        end
        if (bus.mem_read) begin
            n_rd <= n_rd + 1;
            case (bus.mem_funct3)
                3'd0:    r_mem_data <= {{24{mem[a][7]}}, mem[a]};
                3'd1:    r_mem_data <= {{16{mem[a+6'd1][7]}}, mem[a+6'd1], mem[a]};
                3'd2:    r_mem_data <= {mem[a+6'd3], mem[a+6'd2], mem[a+6'd1], mem[a]};
                3'd4:    r_mem_data <= {24'd0, mem[a]};
                3'd5:    r_mem_data <= {16'd0, mem[a+6'd1], mem[a]};
                default: r_mem_data <= 32'd0;
            endcase
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request. Called 1 time unit after a clock edge.
    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] wd, input logic [31:0] ea,
                           input logic [1:0] efault, input logic [31:0] erdata,
                           input int hold);
        int rd0, wr0;
        rd0 = n_rd;
        wr0 = n_wr;
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wd;
        check({tag, ".req_ready"}, bus.req_ready, 1'b1);
        tick();                                     // accept edge N, now in N+1
        bus.req_valid = 1'b0;
        if (efault != 2'd0) begin
            check({tag, ".fast_valid"}, bus.resp_valid, 1'b1);
        end else begin
            check({tag, ".n1_valid"}, bus.resp_valid, 1'b0);
            check({tag, ".rd"}, bus.mem_read, !st);
            check({tag, ".wr"}, bus.mem_write, st);
            check({tag, ".addr"}, bus.mem_addr, ea);
            check({tag, ".f3"}, bus.mem_funct3, f3);
            if (st) check({tag, ".value"}, bus.mem_value, wd);
            tick();                                 // N+2
            check({tag, ".n2_strobe"}, {bus.mem_read, bus.mem_write}, 2'b00);
            check({tag, ".n2_valid"}, bus.resp_valid, 1'b0);
            tick();                                 // N+3
            check({tag, ".n3_valid"}, bus.resp_valid, 1'b1);
        end
        check({tag, ".fault"}, bus.resp_fault, efault);
        check({tag, ".rdata"}, bus.resp_rdata, erdata);
        check({tag, ".faddr"}, bus.resp_fault_addr, ea);
        // busy-time requests must be ignored
        bus.req_valid  = (hold > 0);
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_base   = 32'h10;
        bus.req_offset = 32'h0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_valid"}, bus.resp_valid, 1'b1);
            check({tag, ".hold_rdata"}, bus.resp_rdata, erdata);
            check({tag, ".hold_fault"}, bus.resp_fault, efault);
            check({tag, ".hold_ready"}, bus.req_ready, 1'b0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        tick();                                     // handshake edge
        bus.resp_ready = 1'b0;
        check({tag, ".done_valid"}, bus.resp_valid, 1'b0);
        check({tag, ".done_ready"}, bus.req_ready, 1'b1);
        check({tag, ".n_rd"}, n_rd - rd0, (!st && efault == 2'd0) ? 1 : 0);
        check({tag, ".n_wr"}, n_wr - wr0, ( st && efault == 2'd0) ? 1 : 0);
    endtask

    initial begin
        logic seen_valid;
        errors = 0;
        checks = 0;
        n_rd = 0;
        n_wr = 0;
        r_mem_data = 32'd0;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_base = 32'd0; bus.req_offset = 32'd0; bus.req_wdata = 32'd0;
        bus.resp_ready = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        check("rst.req_ready", bus.req_ready, 1'b1);
        check("rst.resp_valid", bus.resp_valid, 1'b0);
        check("rst.rdata", bus.resp_rdata, 32'd0);
        check("rst.fault", bus.resp_fault, 2'd0);
        check("rst.faddr", bus.resp_fault_addr, 32'd0);
        check("rst.strobes", {bus.mem_read, bus.mem_write}, 2'b00);
        check("rst.mem_addr", bus.mem_addr, 32'd0);
        check("rst.mem_value", bus.mem_value, 32'd0);
        check("rst.mem_f3", bus.mem_funct3, 3'd0);

        //       tag     st    f3    base          off           wdata         ea            flt   rdata         hold
        run_req("lw",    1'b0, 3'd2, 32'h10,       32'h4,        32'h0,        32'h14,       2'd0, 32'h12345678, 0);
        run_req("lb",    1'b0, 3'd0, 32'h20,       32'h0,        32'h0,        32'h20,       2'd0, 32'hFFFFFF80, 0);
        run_req("lbu",   1'b0, 3'd4, 32'h20,       32'h0,        32'h0,        32'h20,       2'd0, 32'h00000080, 0);
        run_req("sh_mis",1'b1, 3'd1, 32'h20,       32'h1,        32'h1234,     32'h21,       2'd1, 32'h0,        0);
        run_req("sw_3c", 1'b1, 3'd2, 32'h30,       32'hC,        32'hCAFEBABE, 32'h3C,       2'd0, 32'h0,        0);
        run_req("lw_3c", 1'b0, 3'd2, 32'h3C,       32'h0,        32'h0,        32'h3C,       2'd0, 32'hCAFEBABE, 0);
        run_req("lhu_3e",1'b0, 3'd5, 32'h40,       32'hFFFFFFFE, 32'h0,        32'h3E,       2'd0, 32'h0000CAFE, 0);
        run_req("sw_3d", 1'b1, 3'd2, 32'h3D,       32'h0,        32'h1,        32'h3D,       2'd1, 32'h0,        0);
        run_req("sw_40", 1'b1, 3'd2, 32'h40,       32'h0,        32'h1,        32'h40,       2'd2, 32'h0,        0);
        run_req("sw_wrp",1'b1, 3'd2, 32'hFFFFFFFC, 32'h8,        32'hA5A55A5A, 32'h4,        2'd0, 32'h0,        0);
        run_req("lw_4",  1'b0, 3'd2, 32'h0,        32'h4,        32'h0,        32'h4,        2'd0, 32'hA5A55A5A, 0);
        run_req("lw_neg",1'b0, 3'd2, 32'h0,        32'hFFFFFFFC, 32'h0,        32'hFFFFFFFC, 2'd2, 32'h0,        0);
        run_req("ld_f3", 1'b0, 3'd3, 32'h10,       32'h0,        32'h0,        32'h10,       2'd3, 32'h0,        0);
        run_req("st_f3", 1'b1, 3'd4, 32'h10,       32'h0,        32'h0,        32'h10,       2'd3, 32'h0,        0);
        run_req("bp",    1'b0, 3'd2, 32'h10,       32'h4,        32'h0,        32'h14,       2'd0, 32'h12345678, 5);
        run_req("bp_flt",1'b1, 3'd0, 32'h3F,       32'h1,        32'h0,        32'h40,       2'd2, 32'h0,        2);

        // reset while waiting for load data
        bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'd2;
        bus.req_base = 32'h14; bus.req_offset = 32'h0;
        tick();                         // accepted, ISSUE
        bus.req_valid = 1'b0;
        tick();                         // WAIT
        check("rstw.in_wait", {bus.resp_valid, bus.req_ready}, 2'b00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstw.req_ready", bus.req_ready, 1'b1);
        check("rstw.resp_valid", bus.resp_valid, 1'b0);
        check("rstw.rdata", bus.resp_rdata, 32'd0);
        check("rstw.mem_addr", bus.mem_addr, 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.resp_valid) seen_valid = 1'b1;
        end
        check("rstw.no_resp", seen_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
